tw_master_arb: RTL

TW_MASTER_ARB -- requirements
Module: tw_master_arb

---
 rtl/tw_master_arb_pkg.sv | 26 ++
 rtl/tw_rr_arb2.sv | 22 ++
 rtl/tw_master_arb.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/tw_master_arb_pkg.sv
// Shared definitions for the two-wire bus master: state encoding and
// frame rising-edge counts.
package tw_master_arb_pkg;

  localparam int unsigned TW_REQ_COUNT = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_HI,
    ST_LO,
    ST_END,
    ST_GAP
  } tw_state_e;

  // Write frame: mode + address + data bits.
  function automatic int unsigned tw_wr_edges(input int unsigned a, input int unsigned d);
    return 1 + a + d;
  endfunction

  // Read frame: mode + address + data bits, plus one edge for slave release.
  function automatic int unsigned tw_rd_edges(input int unsigned a, input int unsigned d);
    return 2 + a + d;
  endfunction

endpackage

// File: rtl/tw_rr_arb2.sv
// Two-way round-robin arbiter; the requester served last loses a tie.
module tw_rr_arb2 (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] grant_c
);

  logic ptr_q;  // 1 = requester 1 wins a tie

  always_comb begin
    grant_c = req;
    if (req == 2'b11) grant_c = ptr_q ? 2'b10 : 2'b01;
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst)               ptr_q <= 1'b0;
    else if (take && (|req)) ptr_q <= grant_c[0];
  end

endmodule

// File: rtl/tw_master_arb.sv
// Two-requester master for the serial two-wire bus: arbitrates, then
// shifts out mode/address/data and, for reads, shifts in slave data.
module tw_master_arb
  import tw_master_arb_pkg::*;
#(
  parameter int unsigned TW_ADDRESS_BITS = 10,
  parameter int unsigned TW_DATA_BITS    = 32,
  parameter int unsigned TW_HALF_DIV     = 4
) (
  input  logic                           in_clk,
  input  logic                           in_rst,
  input  logic [1:0]                     in_req,
  input  logic [1:0]                     in_wr,
  input  logic [2*TW_ADDRESS_BITS-1:0]   in_addr,
  input  logic [2*TW_DATA_BITS-1:0]      in_wdata,
  output logic [1:0]                     out_done,
  output logic [TW_DATA_BITS-1:0]        out_rdata,
  output logic                           out_busy,
  output logic                           out_tw_clock,
  output logic                           out_tw_cs_n,
  inout  wire logic                      tw_data
);

  localparam int unsigned AW   = TW_ADDRESS_BITS;
  localparam int unsigned DW   = TW_DATA_BITS;
  localparam int unsigned H    = TW_HALF_DIV;
  localparam int unsigned TXW  = 1 + AW + DW;
  localparam int unsigned E_WR = tw_wr_edges(AW, DW);
  localparam int unsigned E_RD = tw_rd_edges(AW, DW);
  localparam int unsigned CW   = $clog2(2 * H);
  localparam int unsigned EW   = $clog2(E_RD + 1);

  localparam logic [CW-1:0] HALF_LAST  = CW'(H - 1);
  // One GAP cycle is absorbed by the IDLE grant cycle, keeping cs_n high 2*H cycles.
  localparam logic [CW-1:0] GAP_LAST   = CW'(2 * H - 2);
  localparam logic [EW-1:0] WR_LAST    = EW'(E_WR - 1);
  localparam logic [EW-1:0] RD_LAST    = EW'(E_RD - 1);
  localparam logic [EW-1:0] ADDR_LAST  = EW'(AW);
  localparam logic [EW-1:0] DATA_FIRST = EW'(AW + 1);
  localparam logic [EW-1:0] DATA_LAST  = EW'(AW + DW);

  tw_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [EW-1:0]     edge_q, edge_d;
  logic [TXW-1:0]    tx_q, tx_d;
  logic [DW-1:0]     rx_q, rx_d;
  logic              mode_q, mode_d;
  logic              sel_q, sel_d;
  logic              drive_en_q, drive_en_d;
  logic [1:0]        done_d;
  logic [DW-1:0]     rdata_d;
  logic              clock_d, cs_n_d, busy_d;
  logic              take;
  logic [1:0]        grant_c;
  logic              gidx;
  logic              half_end;
  logic [EW-1:0]     last_edge;

  tw_rr_arb2 u_arb (
    .in_clk  (in_clk),
    .in_rst  (in_rst),
    .req     (in_req),
    .take    (take),
    .grant_c (grant_c)
  );

  assign gidx      = grant_c[1];
  assign half_end  = (cnt_q == HALF_LAST);
  assign last_edge = mode_q ? WR_LAST : RD_LAST;
  assign tw_data   = drive_en_q ? tx_q[TXW-1] : 1'bz;

  // Next-state, frame shifting and next output values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    edge_d     = edge_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    mode_d     = mode_q;
    sel_d      = sel_q;
    drive_en_d = drive_en_q;
    done_d     = 2'b00;
    rdata_d    = out_rdata;
    take       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (|in_req) begin
          take       = 1'b1;
          state_d    = ST_START;
          mode_d     = in_wr[gidx];
          sel_d      = gidx;
          edge_d     = '0;
          drive_en_d = 1'b1;
          tx_d       = {in_wr[gidx],
                        gidx ? in_addr[AW +: AW]  : in_addr[0 +: AW],
                        gidx ? in_wdata[DW +: DW] : in_wdata[0 +: DW]};
        end
      end
      ST_START: begin
        if (half_end) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end
      end
      ST_HI: begin
        if (half_end) begin
          cnt_d = '0;
          if (!mode_q && (edge_q >= DATA_FIRST) && (edge_q <= DATA_LAST))
            rx_d = {rx_q[DW-2:0], tw_data};
          if (edge_q == last_edge) begin
            state_d    = ST_END;
            drive_en_d = 1'b0;
          end else begin
            state_d = ST_LO;
            edge_d  = edge_q + 1'b1;
            tx_d    = tx_q << 1;
            // Turnaround: hand the line to the slave after the address LSB.
            if (!mode_q && (edge_q == ADDR_LAST)) drive_en_d = 1'b0;
          end
        end
      end
      ST_LO: begin
        if (half_end) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end
      end
      ST_END: begin
        if (half_end) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          done_d  = sel_q ? 2'b10 : 2'b01;
          if (!mode_q) rdata_d = rx_q;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    clock_d = (state_d == ST_HI);
    cs_n_d  = (state_d == ST_IDLE) || (state_d == ST_GAP);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      edge_q       <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      mode_q       <= 1'b0;
      sel_q        <= 1'b0;
      drive_en_q   <= 1'b0;
      out_done     <= 2'b00;
      out_rdata    <= '0;
      out_busy     <= 1'b0;
      out_tw_clock <= 1'b0;
      out_tw_cs_n  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      edge_q       <= edge_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      mode_q       <= mode_d;
      sel_q        <= sel_d;
      drive_en_q   <= drive_en_d;
      out_done     <= done_d;
      out_rdata    <= rdata_d;
      out_busy     <= busy_d;
      out_tw_clock <= clock_d;
      out_tw_cs_n  <= cs_n_d;
    end
  end

endmodule
